// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (IF) and a
//   data-memory requester (DM). A request seen while idle is latched into the
//   registered mem_* fields and held until mem_valid returns. The response is
//   then steered to the winner as a one-cycle valid pulse with captured rdata.
//
//   Tie policy: DM always wins by default. When MEM_ARB_RR_EN is defined,
//   ties alternate, going to the requester that was not granted last.
//
// Ports
//   clk, rst                : clock (rising edge), asynchronous active-low reset
//   if_request/we_re/mask/address       : IF request (IF never writes data)
//   if_rdata, if_valid                  : IF response
//   dm_request/we_re/mask/address/wdata : DM request
//   dm_rdata, dm_valid                  : DM response
//   mem_request/we_re/mask/address/wdata: shared memory request (registered)
//   mem_rdata, mem_valid                : shared memory response
//   busy                                : high while a grant is outstanding
module mem_port_arbiter #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_request,
    input  logic                  if_we_re,
    input  logic [3:0]            if_mask,
    input  logic [ADDRESS-1:0]    if_address,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_request,
    input  logic                  dm_we_re,
    input  logic [3:0]            dm_mask,
    input  logic [ADDRESS-1:0]    dm_address,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_request,
    output logic                  mem_we_re,
    output logic [3:0]            mem_mask,
    output logic [ADDRESS-1:0]    mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_pick_if;
    logic                  w_pick_dm;

    logic                  r_mem_request;
    logic                  r_mem_we_re;
    logic [3:0]            r_mem_mask;
    logic [ADDRESS-1:0]    r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  r_dm_valid;
`ifdef MEM_ARB_RR_EN
    logic                  r_last_dm;  // 1: DM was granted last, 0: IF
`endif

    always_comb begin
        w_next_state = r_state;
        w_pick_if    = 1'b0;
        w_pick_dm    = 1'b0;
        case (r_state)
            IDLE: begin
`ifdef MEM_ARB_RR_EN
                if (if_request && dm_request) begin
                    w_pick_dm = ~r_last_dm;
                    w_pick_if = r_last_dm;
                end else begin
                    w_pick_dm = dm_request;
                    w_pick_if = if_request;
                end
`else
                w_pick_dm = dm_request;
                w_pick_if = if_request & ~dm_request;
`endif
                if (w_pick_dm) begin
                    w_next_state = GRANT_DM;
                end else if (w_pick_if) begin
                    w_next_state = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_DM: begin
                if (mem_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_mem_request <= 1'b0;
            r_mem_we_re   <= 1'b0;
            r_mem_mask    <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_if_valid    <= 1'b0;
            r_dm_rdata    <= '0;
            r_dm_valid    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_dm     <= 1'b0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // mem_valid is ignored here; only a new grant is considered.
                    if (w_pick_dm) begin
                        r_mem_request <= 1'b1;
                        r_mem_we_re   <= dm_we_re;
                        r_mem_mask    <= dm_mask;
                        r_mem_address <= dm_address;
                        r_mem_wdata   <= dm_wdata;
`ifdef MEM_ARB_RR_EN
                        r_last_dm     <= 1'b1;
`endif
                    end else if (w_pick_if) begin
                        r_mem_request <= 1'b1;
                        r_mem_we_re   <= if_we_re;
                        r_mem_mask    <= if_mask;
                        r_mem_address <= if_address;
                        r_mem_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
                        r_last_dm     <= 1'b0;
`endif
                    end
                end
                GRANT_IF: begin
                    if (mem_valid) begin
                        r_mem_request <= 1'b0;
                        r_if_rdata    <= mem_rdata;
                        r_if_valid    <= 1'b1;
                    end
                end
                GRANT_DM: begin
                    if (mem_valid) begin
                        r_mem_request <= 1'b0;
                        r_dm_rdata    <= mem_rdata;
                        r_dm_valid    <= 1'b1;
                    end
                end
                default: r_mem_request <= 1'b0;
            endcase
        end
    end

    assign mem_request = r_mem_request;
    assign mem_we_re   = r_mem_we_re;
    assign mem_mask    = r_mem_mask;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign if_rdata    = r_if_rdata;
    assign if_valid    = r_if_valid;
    assign dm_rdata    = r_dm_rdata;
    assign dm_valid    = r_dm_valid;
    assign busy        = (r_state != IDLE);

endmodule
